inst_mem_pipe: RTL and testbench

//  Parametrised, clocked instruction memory for the fetch stage of the pipelined RV32I core.

---
 rtl/inst_mem_pkg.sv | 29 ++
 rtl/inst_mem_rsp_fifo.sv | 74 +++++++
 rtl/inst_mem_pipe.sv | 123 ++++++++++++
 tb/tb_inst_mem_pipe.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the fetch-stage instruction memory.
package inst_mem_pkg;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    localparam logic [1:0]  FLT_OK       = 2'b00;
    localparam logic [1:0]  FLT_MISALIGN = 2'b01;
    localparam logic [1:0]  FLT_RANGE    = 2'b10;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } rsp_entry_t;

    localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

    // Misalignment wins over range; any address bit above the array index means out of range.
    function automatic logic [1:0] fetch_fault(input logic [31:0] pc, input int aw);
        if (pc[1:0] != 2'b00) begin
            return FLT_MISALIGN;
        end
        if ((pc >> (aw + 2)) != 32'd0) begin
            return FLT_RANGE;
        end
        return FLT_OK;
    endfunction

endpackage

// File: rtl/inst_mem_rsp_fifo.sv
// Small in-order response buffer; a synchronous clear drops everything, but a push on the
// clearing edge is kept as the first entry of the new stream.
module inst_mem_rsp_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 66
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic         clr_i,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         empty_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, wr_addr;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_pop  = pop_i & (cnt_q != '0);
    assign do_push = push_i & (clr_i | do_pop | (cnt_q != CW'(DEPTH)));
    assign wr_addr = clr_i ? '0 : wr_q;
    assign rdata_o = mem_q[rd_q];
    assign empty_o = (cnt_q == '0);

    // Pointer and occupancy next-state; clear restarts both pointers at slot 0.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            rd_d  = '0;
            wr_d  = do_push ? ptr_inc('0) : '0;
            cnt_d = CW'(do_push);
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage; zeroed on reset so the head reads all-zero until the first push.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_addr] <= wdata_i;
        end
    end

endmodule

// File: rtl/inst_mem_pipe.sv
// Fetch-stage instruction memory: valid/ready requests, in-order responses after LATENCY
// cycles, credit-based back-pressure, flush for redirects, and a loader write port.
module inst_mem_pipe
    import inst_mem_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter int    LATENCY   = 1,
    parameter string INIT_FILE = ""
) (
    input  logic        Clk,
    input  logic        Resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_pc,
    input  logic        flush,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic [31:0] rsp_pc,
    output logic [1:0]  rsp_fault,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);
    localparam int AW        = $clog2(DEPTH);
    localparam int RSP_DEPTH = LATENCY + 1;
    localparam int CW        = $clog2(RSP_DEPTH + 1);

    if (LATENCY != 1 && LATENCY != 2) begin : g_bad_latency
        $error("inst_mem_pipe: LATENCY must be 1 or 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_mem_pipe: DEPTH must be a power of two");
    end

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] rd_idx, ld_idx;
    logic          accept, pop, push, fifo_empty;
    logic [CW-1:0] cnt_q, cnt_d;
    rsp_entry_t    req_entry, push_entry, head;
    logic          unused_ld_bits;

    assign rd_idx         = req_pc[AW+1:2];
    assign ld_idx         = ld_addr[AW+1:2];
    assign unused_ld_bits = ^{ld_addr[31:AW+2], ld_addr[1:0]};

    assign req_ready = Resetn & ~ld_en & (cnt_q < CW'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;

    // Loader writes; the array itself is never reset.
    always_ff @(posedge Clk) begin
        if (ld_en) mem_q[ld_idx] <= ld_data;
    end

    // Response entry as captured at the accept edge; faulting fetches carry a NOP.
    always_comb begin
        req_entry.pc    = req_pc;
        req_entry.fault = fetch_fault(req_pc, AW);
        req_entry.instr = (req_entry.fault == FLT_OK) ? mem_q[rd_idx] : NOP_INSTR;
    end

    if (LATENCY == 2) begin : g_lat2
        logic       lat_valid_q;
        rsp_entry_t lat_entry_q;

        // Extra stage between array and buffer; a flush suppresses its push while the
        // redirect target accepted on the same edge still loads.
        always_ff @(posedge Clk or negedge Resetn) begin
            if (!Resetn) begin
                lat_valid_q <= 1'b0;
                lat_entry_q <= '0;
            end else begin
                lat_valid_q <= accept;
                if (accept) lat_entry_q <= req_entry;
            end
        end

        assign push       = lat_valid_q & ~flush;
        assign push_entry = lat_entry_q;
    end else begin : g_lat1
        assign push       = accept;
        assign push_entry = req_entry;
    end

    // Credits: in-flight plus buffered; a flush keeps only the same-cycle redirect request.
    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = CW'(accept);
        end else if (accept && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && pop) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Credit counter register.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    inst_mem_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .W     (RSP_ENTRY_W)
    ) u_rsp_fifo (
        .Clk     (Clk),
        .Resetn  (Resetn),
        .clr_i   (flush),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (push_entry),
        .rdata_o (head),
        .empty_o (fifo_empty)
    );

    assign rsp_valid = ~fifo_empty;
    assign rsp_instr = head.instr;
    assign rsp_pc    = head.pc;
    assign rsp_fault = head.fault;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Bench for inst_mem_pipe: a LATENCY=1 and a LATENCY=2 instance driven by the same stimulus,
// each with its own expected-response queue.
module tb_inst_mem_pipe;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [1:0]  fault;
    } exp_t;

    logic        Clk = 1'b0;
    logic        Resetn;
    logic        req_valid, flush, rsp_ready, ld_en;
    logic [31:0] req_pc, ld_addr, ld_data;
    logic [1:0]  req_ready_w, rsp_valid_w;
    logic [31:0] rsp_instr_w [2];
    logic [31:0] rsp_pc_w    [2];
    logic [1:0]  rsp_fault_w [2];
    logic [31:0] mdl [256];
    int          n_checks = 0;
    int          n_pass   = 0;

    always #5 Clk = ~Clk;

    inst_mem_pipe #(.DEPTH(256), .LATENCY(1)) u_dut_l1 (
        .Clk(Clk), .Resetn(Resetn),
        .req_valid(req_valid), .req_ready(req_ready_w[0]), .req_pc(req_pc),
        .flush(flush),
        .rsp_valid(rsp_valid_w[0]), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr_w[0]), .rsp_pc(rsp_pc_w[0]), .rsp_fault(rsp_fault_w[0]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    inst_mem_pipe #(.DEPTH(256), .LATENCY(2)) u_dut_l2 (
        .Clk(Clk), .Resetn(Resetn),
        .req_valid(req_valid), .req_ready(req_ready_w[1]), .req_pc(req_pc),
        .flush(flush),
        .rsp_valid(rsp_valid_w[1]), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr_w[1]), .rsp_pc(rsp_pc_w[1]), .rsp_fault(rsp_fault_w[1]),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic [31:0] pc);
        exp_t e;
        e.pc = pc;
        if (pc[1:0] != 2'b00)       e.fault = 2'b01;
        else if (pc[31:10] != 22'd0) e.fault = 2'b10;
        else                         e.fault = 2'b00;
        e.instr = (e.fault == 2'b00) ? mdl[pc[9:2]] : 32'h0000_0013;
        return e;
    endfunction

    // Reference array follows the loader; the write lands on the coming edge.
    always @(negedge Clk) begin
        if (ld_en) mdl[ld_addr[9:2]] = ld_data;
    end

    // Scoreboards: mid-cycle, decide which handshakes the coming edge completes.
    for (genvar k = 0; k < 2; k++) begin : g_mon
        exp_t q[$];
        always @(negedge Clk) begin
            if (!Resetn) begin
                q.delete();
            end else begin
                if (rsp_valid_w[k]) begin
                    if (q.size() == 0) begin
                        chk($sformatf("L%0d_unexpected_rsp", k + 1), 32'(rsp_valid_w[k]), 32'd0);
                    end else begin
                        chk($sformatf("L%0d_rsp_instr pc=%h", k + 1, q[0].pc), rsp_instr_w[k], q[0].instr);
                        chk($sformatf("L%0d_rsp_pc", k + 1), rsp_pc_w[k], q[0].pc);
                        chk($sformatf("L%0d_rsp_fault pc=%h", k + 1, q[0].pc), 32'(rsp_fault_w[k]), 32'(q[0].fault));
                        if (rsp_ready) void'(q.pop_front());
                    end
                end
                if (flush) q.delete();
                if (req_valid && req_ready_w[k]) q.push_back(model(req_pc));
            end
        end
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic ld(input logic [31:0] a, input logic [31:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        cyc();
        ld_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        req_valid = 1'b0; rsp_ready = 1'b1; flush = 1'b0;
        for (int i = 0; i < 20 && (g_mon[0].q.size() != 0 || g_mon[1].q.size() != 0); i++) cyc();
        cyc();
        chk({tag, "_drain_L1"}, 32'(g_mon[0].q.size()), 32'd0);
        chk({tag, "_drain_L2"}, 32'(g_mon[1].q.size()), 32'd0);
        chk({tag, "_idle_valid"}, 32'(rsp_valid_w), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] fpcs [4];
        logic [31:0] init_w [4];
        fpcs   = '{32'h0000_0002, 32'h0000_0400, 32'h8000_0002, 32'h0000_003C};
        init_w = '{32'h11, 32'h22, 32'h33, 32'h44};

        Resetn = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid_w), 32'd0);
        chk("rst_req_ready", 32'(req_ready_w), 32'd0);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_instr_L%0d", k + 1), rsp_instr_w[k], 32'd0);
            chk($sformatf("rst_pc_L%0d", k + 1), rsp_pc_w[k], 32'd0);
            chk($sformatf("rst_fault_L%0d", k + 1), 32'(rsp_fault_w[k]), 32'd0);
        end
        repeat (2) @(posedge Clk);
        #1 Resetn = 1'b1;
        @(negedge Clk);
        chk("ready_after_rst", 32'(req_ready_w), 32'd3);
        cyc();

        for (int i = 0; i < 20; i++) ld(32'(i * 4), (i < 4) ? init_w[i] : 32'h1000_0000 + 32'(i));

        // Back-to-back fetches of words 0..3 with no back-pressure.
        rsp_ready = 1'b1;
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 4);
            req_pc    = 32'(c * 4);
            @(negedge Clk);
            chk($sformatf("stream_valid_L1_c%0d", c), 32'(rsp_valid_w[0]), 32'(c >= 1 && c <= 4));
            chk($sformatf("stream_valid_L2_c%0d", c), 32'(rsp_valid_w[1]), 32'(c >= 2 && c <= 5));
            cyc();
        end
        drain("stream");

        // Five-cycle consumer stall in the middle of a continuous request stream.
        for (int i = 0; i < 14; i++) begin
            req_valid = 1'b1;
            req_pc    = 32'((i % 16) * 4);
            rsp_ready = !(i >= 4 && i < 9);
            @(negedge Clk);
            if (i == 8) begin
                chk("stall_req_ready", 32'(req_ready_w), 32'd0);
                chk("stall_rsp_valid", 32'(rsp_valid_w), 32'd3);
                chk("stall_cnt_L1", 32'(g_mon[0].q.size()), 32'd2);
                chk("stall_cnt_L2", 32'(g_mon[1].q.size()), 32'd3);
            end
            cyc();
        end
        drain("stall");

        // Fault tagging: misaligned, out of range, priority, then a good word.
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_pc    = fpcs[i];
            cyc();
        end
        drain("fault");

        // Flush with two entries outstanding and a redirect to 0x40 in the same cycle.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        cyc();
        req_pc    = 32'h4;
        cyc();
        flush  = 1'b1;
        req_pc = 32'h40;
        @(negedge Clk);
        chk("flush_req_ready", 32'(req_ready_w), 32'b10);
        cyc();
        flush = 1'b0;
        @(negedge Clk);
        chk("flush_valid_after", 32'(rsp_valid_w), 32'd0);
        cyc();
        drain("flush");

        // Loader write blocks the request; the next-cycle fetch sees the new word.
        req_valid = 1'b1;
        req_pc    = 32'h10;
        ld_en     = 1'b1;
        ld_addr   = 32'h10;
        ld_data   = 32'hDEAD_BEEF;
        rsp_ready = 1'b1;
        @(negedge Clk);
        chk("ld_blocks_req", 32'(req_ready_w), 32'd0);
        cyc();
        ld_en = 1'b0;
        @(negedge Clk);
        chk("ld_release_ready", 32'(req_ready_w), 32'd3);
        cyc();
        drain("loader");

        // Asynchronous reset with two responses pending.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_pc    = 32'h0;
        cyc();
        req_pc = 32'h4;
        cyc();
        req_valid = 1'b0;
        @(negedge Clk);
        chk("pre_rst_valid", 32'(rsp_valid_w), 32'd3);
        @(posedge Clk);
        #3 Resetn = 1'b0;
        #1;
        chk("async_rst_valid", 32'(rsp_valid_w), 32'd0);
        chk("async_rst_ready", 32'(req_ready_w), 32'd0);
        repeat (2) @(posedge Clk);
        #1 Resetn = 1'b1;
        rsp_ready = 1'b1;
        @(negedge Clk);
        chk("post_rst_ready", 32'(req_ready_w), 32'd3);
        cyc();
        req_valid = 1'b1;
        req_pc    = 32'h8;
        cyc();
        drain("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
